// File: rtl/soc_fb_rect_fill_if.sv
// Framebuffer write-port bundle between the rectangle fill engine (master)
// and the framebuffer's main-clock memory port (slave).
interface soc_fb_rect_fill_if #(
    parameter int FB_ADDR_WIDTH = 18
);
    logic                     mem_req;
    logic                     mem_we;
    logic [FB_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_be;
    logic                     mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready
    );
endinterface

// File: rtl/soc_fb_rect_fill.sv
// Rectangle fill engine: writes one byte colour into every pixel of a rectangle, one pixel per transfer.
// Define FILL_CLIP_EN to clip the rectangle to the framebuffer at start; otherwise columns/addresses wrap.
module soc_fb_rect_fill #(
    parameter int FB_ADDR_WIDTH = 18,
    parameter int FB_BASE       = 0,
    parameter int FB_WIDTH      = 640,
    parameter int FB_HEIGHT     = 480,
    parameter int COORD_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] cfg_x,
    input  logic [COORD_WIDTH-1:0] cfg_y,
    input  logic [COORD_WIDTH-1:0] cfg_w,
    input  logic [COORD_WIDTH-1:0] cfg_h,
    input  logic [7:0]             cfg_color,
    output logic                   busy,
    output logic                   done,
    soc_fb_rect_fill_if.master     mem
);
    localparam int OFF_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [OFF_W-1:0]       r_off;
    logic [OFF_W-1:0]       w_off_start;
    logic [COORD_WIDTH-1:0] r_w;
    logic [COORD_WIDTH-1:0] r_h;
    logic [COORD_WIDTH-1:0] r_col;
    logic [COORD_WIDTH-1:0] r_row;
    logic [COORD_WIDTH-1:0] w_cw;
    logic [COORD_WIDTH-1:0] w_ch;
    logic [7:0]             r_color;
    logic                   w_xfer;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_empty;

`ifdef FILL_CLIP_EN
    always_comb begin
        w_cw = cfg_w;
        w_ch = cfg_h;
        if (int'(cfg_x) >= FB_WIDTH || int'(cfg_y) >= FB_HEIGHT) begin
            w_cw = '0;
            w_ch = '0;
        end else begin
            if (int'(cfg_w) > FB_WIDTH - int'(cfg_x))
                w_cw = COORD_WIDTH'(FB_WIDTH - int'(cfg_x));
            if (int'(cfg_h) > FB_HEIGHT - int'(cfg_y))
                w_ch = COORD_WIDTH'(FB_HEIGHT - int'(cfg_y));
        end
    end
`else
    assign w_cw = cfg_w;
    assign w_ch = cfg_h;
`endif

    // The only multiply is the start offset; per-pixel stepping is additive.
    assign w_off_start = OFF_W'(cfg_y) * OFF_W'(FB_WIDTH) + OFF_W'(cfg_x);
    assign w_empty     = (w_cw == '0) || (w_ch == '0);
    assign w_xfer      = (r_state == S_WRITE) && mem.mem_ready;
    assign w_last_col  = (r_col == r_w - COORD_WIDTH'(1));
    assign w_last_row  = (r_row == r_h - COORD_WIDTH'(1));

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_be    = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = w_empty ? S_FINISH : S_WRITE;
            end
            S_WRITE: begin
                busy          = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = FB_ADDR_WIDTH'(OFF_W'(FB_BASE) + (r_off >> 2));
                mem.mem_wdata = {4{r_color}};
                mem.mem_be    = 4'b0001 << r_off[1:0];
                if (w_xfer && w_last_col && w_last_row) w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers are qualified by the state machine and need no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_w     <= w_cw;
            r_h     <= w_ch;
            r_color <= cfg_color;
            r_col   <= '0;
            r_row   <= '0;
            r_off   <= w_off_start;
        end else if (w_xfer) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + COORD_WIDTH'(1);
                r_off <= r_off + OFF_W'(FB_WIDTH) - OFF_W'(r_w) + OFF_W'(1);
            end else begin
                r_col <= r_col + COORD_WIDTH'(1);
                r_off <= r_off + OFF_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_soc_fb_rect_fill.sv
// Directed bench for soc_fb_rect_fill: write sequences, latency, stalls, empty areas and reset.
module tb_soc_fb_rect_fill;
    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic [9:0] cfg_x, cfg_y, cfg_w, cfg_h;
    logic [7:0] cfg_color;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] q_addr[$];
    logic [3:0]  q_be[$];
    logic [31:0] q_wdata[$];
    int          exp_off[$];

    logic        hold_pend = 1'b0;
    logic [17:0] hold_addr;
    logic [3:0]  hold_be;
    int          lat;

    soc_fb_rect_fill_if #(.FB_ADDR_WIDTH(18)) mem_bus ();

    soc_fb_rect_fill dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .cfg_color (cfg_color),
        .busy      (busy),
        .done      (done),
        .mem       (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge, so values at negedge are what the next edge sees.
    always @(negedge clk) begin
        if (hold_pend) begin
            check_eq("hold_req",  mem_bus.mem_req, 1);
            check_eq("hold_addr", mem_bus.mem_addr, hold_addr);
            check_eq("hold_be",   mem_bus.mem_be, hold_be);
        end
        if (mem_bus.mem_req && mem_bus.mem_ready) begin
            q_addr.push_back(mem_bus.mem_addr);
            q_be.push_back(mem_bus.mem_be);
            q_wdata.push_back(mem_bus.mem_wdata);
            check_eq("we_on_req", mem_bus.mem_we, 1);
        end
        hold_pend = mem_bus.mem_req && !mem_bus.mem_ready;
        hold_addr = mem_bus.mem_addr;
        hold_be   = mem_bus.mem_be;
    end

    task automatic run_fill(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                            input logic [9:0] h, input logic [7:0] c, input bit tog,
                            input bit poke, output int latency);
        int cyc;
        q_addr.delete();
        q_be.delete();
        q_wdata.delete();
        @(posedge clk); #1;
        cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h; cfg_color = c;
        start = 1'b1;
        mem_bus.mem_ready = tog ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check_eq("busy_after_start", busy, 1);
        while (!done && cyc < 400) begin
            if (tog) mem_bus.mem_ready = ~mem_bus.mem_ready;
            if (poke && cyc == 2) begin
                start = 1'b1; cfg_x = 10'd100; cfg_w = 10'd1; cfg_color = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) check_eq("done_timeout", 0, 1);
        latency = cyc;
        start = 1'b0;
        mem_bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_after_done", busy, 0);
    endtask

    task automatic expect_writes(input string tag, input logic [7:0] c);
        int n;
        check_eq({tag, "_count"}, q_addr.size(), exp_off.size());
        n = (q_addr.size() < exp_off.size()) ? q_addr.size() : exp_off.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), q_addr[i], exp_off[i] >> 2);
            check_eq($sformatf("%s_be%0d", tag, i), q_be[i], 4'b0001 << (exp_off[i] % 4));
            check_eq($sformatf("%s_wdata%0d", tag, i), q_wdata[i], {4{c}});
        end
    endtask

    initial begin
        res = 1'b1; start = 1'b0;
        cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_color = '0;
        mem_bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_req",   mem_bus.mem_req, 0);
        check_eq("rst_we",    mem_bus.mem_we, 0);
        check_eq("rst_addr",  mem_bus.mem_addr, 0);
        check_eq("rst_wdata", mem_bus.mem_wdata, 0);
        check_eq("rst_be",    mem_bus.mem_be, 0);
        res = 1'b0;

        // Basic four-pixel fill at the origin.
        run_fill(10'd0, 10'd0, 10'd4, 10'd1, 8'hA5, 1'b0, 1'b0, lat);
        check_eq("t1_latency", lat, 5);
        exp_off = '{0, 1, 2, 3};
        expect_writes("t1", 8'hA5);

        // Same fill with ready toggling 1-0-1-0.
        run_fill(10'd0, 10'd0, 10'd4, 10'd1, 8'hA5, 1'b1, 1'b0, lat);
        check_eq("t2_latency", lat, 8);
        expect_writes("t2", 8'hA5);

        // Rectangle crossing the right edge of the frame.
        run_fill(10'd638, 10'd1, 10'd4, 10'd2, 8'h5A, 1'b0, 1'b0, lat);
`ifdef FILL_CLIP_EN
        check_eq("t3_latency", lat, 5);
        exp_off = '{1278, 1279, 1918, 1919};
`else
        check_eq("t3_latency", lat, 9);
        exp_off = '{1278, 1279, 1280, 1281, 1918, 1919, 1920, 1921};
`endif
        expect_writes("t3", 8'h5A);

        // Two full lines away from the origin.
        run_fill(10'd2, 10'd3, 10'd3, 10'd2, 8'h0F, 1'b0, 1'b0, lat);
        check_eq("t4_latency", lat, 7);
        exp_off = '{1922, 1923, 1924, 2562, 2563, 2564};
        expect_writes("t4", 8'h0F);

        run_fill(10'd5, 10'd5, 10'd0, 10'd3, 8'hFF, 1'b0, 1'b0, lat);
        check_eq("t5_w0_latency", lat, 1);
        check_eq("t5_w0_writes", q_addr.size(), 0);

        run_fill(10'd5, 10'd5, 10'd3, 10'd0, 8'hFF, 1'b0, 1'b0, lat);
        check_eq("t6_h0_latency", lat, 1);
        check_eq("t6_h0_writes", q_addr.size(), 0);

`ifdef FILL_CLIP_EN
        run_fill(10'd640, 10'd0, 10'd5, 10'd1, 8'hEE, 1'b0, 1'b0, lat);
        check_eq("t6c_offscreen_latency", lat, 1);
        check_eq("t6c_offscreen_writes", q_addr.size(), 0);
`endif

        // A start pulse during a fill must be ignored.
        run_fill(10'd0, 10'd10, 10'd6, 10'd1, 8'h77, 1'b0, 1'b1, lat);
        check_eq("t7_latency", lat, 7);
        exp_off = '{6400, 6401, 6402, 6403, 6404, 6405};
        expect_writes("t7", 8'h77);

        // Asynchronous reset in the middle of a fill, then a fresh fill.
        @(posedge clk); #1;
        cfg_x = 10'd0; cfg_y = 10'd0; cfg_w = 10'd16; cfg_h = 10'd4; cfg_color = 8'h11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_eq("pre_rst_req", mem_bus.mem_req, 1);
        res = 1'b1;
        #1;
        check_eq("mid_rst_req",  mem_bus.mem_req, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_be",   mem_bus.mem_be, 0);
        @(posedge clk); #1;
        check_eq("rst_hold_busy", busy, 0);
        res = 1'b0;
        run_fill(10'd4, 10'd2, 10'd3, 10'd1, 8'h3C, 1'b0, 1'b0, lat);
        check_eq("t8_latency", lat, 4);
        exp_off = '{1284, 1285, 1286};
        expect_writes("t8", 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
